vga_scanout: RTL and testbench

- Parametrised successor to the fixed 1280x1024 monochrome display engine.
- Generates VGA timing for any mode and fetches a linear frame buffer through a VRAM request/ready handshake into a small word FIFO.
- Serialises 1/2/4/8 bits-per-pixel data into a centred box with an optional 1-pixel border.
- Sits between the VRAM arbiter and the board VGA DAC pins; runs entirely on the pixel clock.

---
 rtl/vga_scanout.sv | 185 ++++++++++++++++++
 tb/tb_vga_scanout.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA timing generator with a linear frame-buffer fetch into a word FIFO and a
// 1/2/4/8 bpp serialiser that draws a centred box with an optional 1-pixel border.
module vga_scanout #(
  parameter int H_DISP     = 1280,
  parameter int H_FPORCH   = 16,
  parameter int H_SYNC     = 144,
  parameter int H_BPORCH   = 248,
  parameter int V_DISP     = 1024,
  parameter int V_FPORCH   = 1,
  parameter int V_SYNC     = 3,
  parameter int V_BPORCH   = 38,
  parameter int BOX_WIDTH  = 768,
  parameter int BOX_HEIGHT = 896,
  parameter int WORD_W     = 32,
  parameter int BPP        = 1,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_NEG   = 1,
  parameter int BORDER_EN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_req,
  input  logic              vram_ready,
  input  logic [WORD_W-1:0] vram_data,
  output logic [BPP-1:0]    vga_pixel,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              underflow
);

  localparam int H_TOTAL     = H_DISP + H_FPORCH + H_SYNC + H_BPORCH;
  localparam int V_TOTAL     = V_DISP + V_FPORCH + V_SYNC + V_BPORCH;
  localparam int HW          = $clog2(H_TOTAL);
  localparam int VW          = $clog2(V_TOTAL);
  localparam int HOFF        = (H_DISP - BOX_WIDTH) / 2;
  localparam int VOFF        = (V_DISP - BOX_HEIGHT) / 2;
  localparam int PPW         = WORD_W / BPP;
  localparam int WORDS_FRAME = BOX_WIDTH * BPP / WORD_W * BOX_HEIGHT;
  localparam int WFW         = $clog2(WORDS_FRAME + 1);
  localparam int FW          = $clog2(FIFO_DEPTH);
  localparam int SCW         = $clog2(PPW + 1);

  typedef enum logic {IDLE, REQ} state_t;

  function automatic logic box_at(int h, int v);
    return h >= HOFF && h < HOFF + BOX_WIDTH && v >= VOFF && v < VOFF + BOX_HEIGHT;
  endfunction

  function automatic logic border_at(int h, int v);
    logic col, row;
    col = (h == HOFF - 1 || h == HOFF + BOX_WIDTH) && v >= VOFF - 1 && v <= VOFF + BOX_HEIGHT;
    row = (v == VOFF - 1 || v == VOFF + BOX_HEIGHT) && h >= HOFF - 1 && h <= HOFF + BOX_WIDTH;
    return BORDER_EN != 0 && (col || row);
  endfunction

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic          h_wrap, v_wrap, in_box, in_box_nxt, visible, restart;
  logic          hs_act, vs_act;

  state_t                         state;
  logic [WFW-1:0]                 words;
  logic [FIFO_DEPTH-1:0][WORD_W-1:0] fifo_mem;
  logic [FW-1:0]                  wr_ptr, rd_ptr;
  logic [FW:0]                    fifo_cnt;
  logic                           fifo_wr, fifo_rd, load_need;

  logic [WORD_W-1:0] shift;
  logic [SCW-1:0]    sh_cnt, sh_left;
  logic [BPP-1:0]    pix_d;

  always_comb begin
    h_wrap     = h_cnt == HW'(H_TOTAL - 1);
    v_wrap     = v_cnt == VW'(V_TOTAL - 1);
    h_nxt      = h_wrap ? '0 : h_cnt + HW'(1);
    v_nxt      = h_wrap ? (v_wrap ? '0 : v_cnt + VW'(1)) : v_cnt;
    in_box     = box_at(int'(h_cnt), int'(v_cnt));
    in_box_nxt = box_at(int'(h_nxt), int'(v_nxt));
    visible    = int'(h_cnt) < H_DISP && int'(v_cnt) < V_DISP;
    restart    = h_cnt == '0 && int'(v_cnt) == V_DISP;
    hs_act     = int'(h_cnt) >= H_DISP + H_FPORCH && int'(h_cnt) < H_DISP + H_FPORCH + H_SYNC;
    vs_act     = int'(v_cnt) >= V_DISP + V_FPORCH && int'(v_cnt) < V_DISP + V_FPORCH + V_SYNC;
  end

  // The shifter reloads one cycle ahead so the first box pixel comes straight from the new word.
  always_comb begin
    sh_left   = (in_box && sh_cnt != '0) ? sh_cnt - SCW'(1) : sh_cnt;
    load_need = sh_left == '0 && in_box_nxt;
    fifo_rd   = load_need && fifo_cnt != '0 && !restart;
    fifo_wr   = state == REQ && vram_ready && !restart;
    pix_d     = '0;
    if (visible) begin
      if (border_at(int'(h_cnt), int'(v_cnt))) pix_d = '1;
      else if (in_box && sh_cnt != '0)        pix_d = shift[BPP-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      vga_pixel <= '0;
      vga_hsync <= 1'(SYNC_NEG);
      vga_vsync <= 1'(SYNC_NEG);
    end else begin
      h_cnt     <= h_nxt;
      v_cnt     <= v_nxt;
      vga_pixel <= pix_d;
      vga_hsync <= hs_act ^ 1'(SYNC_NEG);
      vga_vsync <= vs_act ^ 1'(SYNC_NEG);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      vram_req  <= 1'b0;
      vram_addr <= '0;
      words     <= '0;
    end else if (restart) begin
      state     <= IDLE;
      vram_req  <= 1'b0;
      vram_addr <= '0;
      words     <= '0;
    end else begin
      case (state)
        IDLE: if (fifo_cnt < (FW+1)'(FIFO_DEPTH) && words < WFW'(WORDS_FRAME)) begin
          state    <= REQ;
          vram_req <= 1'b1;
        end
        REQ: if (vram_ready) begin
          state     <= IDLE;
          vram_req  <= 1'b0;
          vram_addr <= vram_addr + ADDR_W'(1);
          words     <= words + WFW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= vram_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (restart) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + FW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + FW'(1);
      fifo_cnt <= fifo_cnt + (FW+1)'(fifo_wr) - (FW+1)'(fifo_rd);
    end
  end

  // An empty FIFO leaves the shifter empty, so it retries on every following pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift     <= '0;
      sh_cnt    <= '0;
      underflow <= 1'b0;
    end else if (restart) begin
      shift  <= '0;
      sh_cnt <= '0;
    end else begin
      if (fifo_rd) begin
        shift  <= fifo_mem[rd_ptr];
        sh_cnt <= SCW'(PPW);
      end else if (in_box && sh_cnt != '0) begin
        shift  <= shift >> BPP;
        sh_cnt <= sh_cnt - SCW'(1);
      end
      if (load_need && fifo_cnt == '0) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: three small-mode instances (1bpp+border, 2bpp no border,
// 2bpp slow VRAM) checked every pixel against a geometric model of the frame.
module tb_vga_scanout;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0]       req, hs, vs, uf, rdy;
  logic [NI-1:0][7:0]  addr, dat;
  logic [NI-1:0][1:0]  pix;
  logic [7:0]          mem [NI][16];

  int  checks = 0, failures = 0;
  int  k;
  int  wcnt [NI];
  bit  want_first [NI];
  int  last_hf, last_vf;
  logic prev_hs2, prev_vs2;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int B  = (g == 0) ? 1 : 2;
    localparam int D  = (g == 2) ? 2 : 4;
    localparam int BE = (g == 1) ? 0 : 1;
    logic [B-1:0] p;
    vga_scanout #(
      .H_DISP(16), .H_FPORCH(2), .H_SYNC(3), .H_BPORCH(3),
      .V_DISP(8), .V_FPORCH(1), .V_SYNC(2), .V_BPORCH(1),
      .BOX_WIDTH(8), .BOX_HEIGHT(4), .WORD_W(8), .BPP(B), .ADDR_W(8),
      .FIFO_DEPTH(D), .SYNC_NEG(1), .BORDER_EN(BE)
    ) u_dut (
      .clk(clk), .reset(reset), .vram_addr(addr[g]), .vram_req(req[g]),
      .vram_ready(rdy[g]), .vram_data(dat[g]), .vga_pixel(p),
      .vga_hsync(hs[g]), .vga_vsync(vs[g]), .underflow(uf[g])
    );
    assign pix[g] = 2'(p);
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0d exp=%0d", tag, k, got, exp);
    end
  endtask

  function automatic int bpp_of(int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int brd_of(int i); return (i == 1) ? 0 : 1; endfunction

  // Expected pixel for raster position c (pixel clocks since reset release).
  function automatic int exp_pix(int i, int c, output bit dc);
    int h, v, b, off, w;
    h = c % 24; v = (c / 24) % 12; b = bpp_of(i); dc = 0;
    if (h >= 16 || v >= 8) return 0;
    if (brd_of(i) != 0 && (((h == 3 || h == 12) && v >= 1 && v <= 6) ||
                           ((v == 1 || v == 6) && h >= 3 && h <= 12)))
      return (1 << b) - 1;
    if (h >= 4 && h < 12 && v >= 2 && v < 6) begin
      off = (h - 4) * b;
      w   = (v - 2) * b + off / 8;
      dc  = (i == 2);
      return (int'(mem[i][w]) >> (off % 8)) & ((1 << b) - 1);
    end
    return 0;
  endfunction

  task automatic restart_model();
    k = 0;
    last_hf = -1; last_vf = -1;
    prev_hs2 = 1'b1; prev_vs2 = 1'b1;
    for (int i = 0; i < NI; i++) begin
      wcnt[i] = -1;
      want_first[i] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    k++;
    for (int i = 0; i < NI; i++) begin
      int  c, h, v, ep;
      bit  dc;
      c  = k - 1;
      h  = c % 24;
      v  = (c / 24) % 12;
      ep = exp_pix(i, c, dc);
      if (!dc) chk($sformatf("pix%0d", i), 32'(pix[i]), ep);
      chk($sformatf("hs%0d", i), 32'(hs[i]), (h >= 18 && h < 21) ? 0 : 1);
      chk($sformatf("vs%0d", i), 32'(vs[i]), (v >= 9 && v < 11) ? 0 : 1);
      if (k % 288 == 193) want_first[i] = 1'b1;
      // VRAM responder: ready after a latency counted from when the request is seen
      rdy[i] = 1'b0;
      if (req[i]) begin
        if (want_first[i]) begin
          chk($sformatf("first_addr%0d", i), 32'(addr[i]), 0);
          want_first[i] = 1'b0;
        end
        if (wcnt[i] < 0) wcnt[i] = (i == 2) ? 20 : int'($urandom_range(0, 2));
        if (wcnt[i] == 0) begin
          rdy[i]  = 1'b1;
          dat[i]  = mem[i][addr[i][3:0]];
          wcnt[i] = -1;
        end else wcnt[i]--;
      end else wcnt[i] = -1;
    end
    // unsolicited ready landing on the frame-restart cycle must be dropped
    if (k % 288 == 192) begin
      rdy[0] = 1'b1;
      dat[0] = 8'hA5;
    end
    if (prev_hs2 && !hs[2]) begin
      if (last_hf >= 0) chk("hperiod2", k - last_hf, 24);
      last_hf = k;
    end
    if (prev_vs2 && !vs[2]) begin
      if (last_vf >= 0) chk("vperiod2", k - last_vf, 288);
      last_vf = k;
    end
    prev_hs2 = hs[2];
    prev_vs2 = vs[2];
  endtask

  initial begin
    int n;
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < 16; j++) mem[i][j] = 8'($urandom);
    mem[0][1] = 8'h01;
    mem[1][0] = 8'h1B;
    rdy = '0;
    dat = '0;
    k = 0;
    restart_model();

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_req%0d", i), 32'(req[i]), 0);
      chk($sformatf("rst_pix%0d", i), 32'(pix[i]), 0);
      chk($sformatf("rst_hs%0d", i), 32'(hs[i]), 1);
      chk($sformatf("rst_vs%0d", i), 32'(vs[i]), 1);
      chk($sformatf("rst_uf%0d", i), 32'(uf[i]), 0);
    end
    #1 reset = 1'b0;
    restart_model();

    repeat (3 * 288) step();
    chk("uf0", 32'(uf[0]), 0);
    chk("uf1", 32'(uf[1]), 0);
    chk("uf2", 32'(uf[2]), 1);

    // Reset in the middle of a request
    n = 0;
    while (!req[0] && n < 300) begin
      step();
      n++;
    end
    chk("req_seen", 32'(req[0]), 1);
    #2 reset = 1'b1;
    #1;
    chk("req_drop", 32'(req[0]), 0);
    chk("uf_clr", 32'(uf[2]), 0);
    rdy[0] = 1'b1;
    dat[0] = 8'hEE;
    @(posedge clk);
    #1 rdy = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    restart_model();

    repeat (2 * 288) step();
    chk("uf0_end", 32'(uf[0]), 0);
    chk("uf1_end", 32'(uf[1]), 0);
    chk("uf2_end", 32'(uf[2]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
